// File: rtl/mc6502_interrupt_sequencer.sv
// mc6502_interrupt_sequencer: reset/NMI/IRQ/BRK entry sequencer for the mc6502 core
// Ports:
//   clk, rst_x (async, active-low), cen (clock enable)
//   i_nmi_n (falling-edge NMI), i_irq_n (level IRQ), i_brk, i_fetch (instruction boundary)
//   i_pc / i_sp / i_psr : return PC, stack pointer, status register from the core
//   i_rdata             : bus read data (vector bytes)
//   o_busy              : sequence active, core stalls
//   o_addr/o_wdata/o_we : bus address, write data, write strobe
//   o_sp_dec            : core decrements SP this cycle
//   o_set_i/o_i, o_set_b/o_b, o_set_d/o_d : status flag write enables / values
//   o_pc_load/o_pc      : load vector PC into the core
// Build option: MC6502_CMOS_CLEAR_D_EN - VEC_L also clears D (65C02 behaviour).
module mc6502_interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RES_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        cen,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_brk,
    input  logic        i_fetch,
    input  logic [15:0] i_pc,
    input  logic [7:0]  i_sp,
    input  logic [7:0]  i_psr,
    input  logic [7:0]  i_rdata,
    output logic        o_busy,
    output logic [15:0] o_addr,
    output logic [7:0]  o_wdata,
    output logic        o_we,
    output logic        o_sp_dec,
    output logic        o_set_i,
    output logic        o_i,
    output logic        o_set_b,
    output logic        o_b,
    output logic        o_set_d,
    output logic        o_d,
    output logic        o_pc_load,
    output logic [15:0] o_pc
);
    typedef enum logic [2:0] {IDLE, DUMMY, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD} state_t;
    localparam logic [1:0] T_RES = 2'd0, T_NMI = 2'd1, T_IRQ = 2'd2, T_BRK = 2'd3;

    state_t      r_state, w_next;
    logic [1:0]  r_kind, w_kind;
    logic        r_res_pend, r_nmi_pend, r_nmi_prev, r_hijack;
    logic [15:0] r_pc, r_vec_pc, w_vec;
    logic [7:0]  r_sp;
    logic        w_nmi_edge, w_irq, w_start, w_push, w_bpush;

    assign w_nmi_edge = cen & r_nmi_prev & ~i_nmi_n;
    assign w_irq      = ~i_irq_n & ~i_psr[2];
    assign w_start    = r_res_pend | (i_fetch & (r_nmi_pend | w_irq | i_brk));
    assign w_kind     = r_res_pend ? T_RES : r_nmi_pend ? T_NMI : w_irq ? T_IRQ : T_BRK;
    assign w_push     = (r_state == PUSH_H) | (r_state == PUSH_L) | (r_state == PUSH_P);
    assign w_bpush    = (r_kind == T_BRK);
    // A hijacked IRQ/BRK keeps its B value but takes the NMI vector
    assign w_vec      = (r_kind == T_RES) ? RES_VEC : ((r_kind == T_NMI) | r_hijack) ? NMI_VEC : IRQ_VEC;
    assign o_pc       = r_vec_pc;

    always_ff @(posedge clk or negedge rst_x)
        if (!rst_x)
            r_state <= IDLE;
        else if (cen)
            r_state <= w_next;

    always_comb begin
        w_next    = (r_state == IDLE) ? (w_start ? DUMMY : IDLE) :
                    (r_state == LOAD) ? IDLE : state_t'(r_state + 3'd1);
        o_busy    = (r_state != IDLE);
        o_addr    = (r_state == DUMMY) ? r_pc :
                    w_push             ? {8'h01, r_sp} :
                    (r_state == VEC_L) ? w_vec :
                    (r_state == VEC_H) ? w_vec + 16'd1 : 16'h0000;
        // Pushed P always has bit 5 set and B reflecting BRK
        o_wdata   = (r_state == PUSH_H) ? r_pc[15:8] :
                    (r_state == PUSH_L) ? r_pc[7:0] :
                    (r_state == PUSH_P) ? ((i_psr & 8'hCF) | {3'b001, w_bpush, 4'h0}) : 8'h00;
        // Reset walks the stack with reads only
        o_we      = w_push & (r_kind != T_RES);
        o_sp_dec  = w_push;
        o_set_i   = (r_state == VEC_L);
        o_i       = (r_state == VEC_L);
        o_set_b   = (r_state == VEC_L);
        o_b       = (r_state == VEC_L) & w_bpush;
`ifdef MC6502_CMOS_CLEAR_D_EN
        o_set_d   = (r_state == VEC_L);
`else
        o_set_d   = 1'b0;
`endif
        o_d       = 1'b0;
        o_pc_load = (r_state == LOAD);
    end

    always_ff @(posedge clk or negedge rst_x)
        if (!rst_x) begin
            r_res_pend <= 1'b1;
            r_nmi_pend <= 1'b0;
            r_nmi_prev <= 1'b1;
            r_hijack   <= 1'b0;
            r_kind     <= T_RES;
            r_pc       <= 16'h0000;
            r_sp       <= 8'h00;
            r_vec_pc   <= 16'h0000;
        end else if (cen) begin
            r_nmi_prev <= i_nmi_n;
            // A new edge wins over the clear so it is never lost
            r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~((r_state == VEC_L) & ((r_kind == T_NMI) | r_hijack)));
            if ((r_state == IDLE) & w_start) begin
                r_kind <= w_kind;
                r_pc   <= i_pc;
                r_sp   <= i_sp;
            end
            if (w_push)
                r_sp <= r_sp - 8'd1;
            // Decide hijack as the pushes finish: any NMI pending by then redirects IRQ/BRK
            if (r_state == PUSH_P)
                r_hijack <= r_kind[1] & (r_nmi_pend | w_nmi_edge);
            if (r_state == VEC_L) begin
                r_vec_pc[7:0] <= i_rdata;
                r_res_pend    <= 1'b0;
            end
            if (r_state == VEC_H)
                r_vec_pc[15:8] <= i_rdata;
        end
endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// tb_mc6502_interrupt_sequencer: directed and randomized checks against a cycle model
module tb_mc6502_interrupt_sequencer;
    logic        clk = 1'b0, rst_x = 1'b0, cen = 1'b1;
    logic        i_nmi_n = 1'b1, i_irq_n = 1'b1, i_brk = 1'b0, i_fetch = 1'b0;
    logic [15:0] i_pc = 16'h0000;
    logic [7:0]  i_sp = 8'h00, i_psr = 8'h00, i_rdata;
    logic        o_busy, o_we, o_sp_dec, o_set_i, o_i, o_set_b, o_b, o_set_d, o_d, o_pc_load;
    logic [15:0] o_addr, o_pc;
    logic [7:0]  o_wdata;
    int          tests = 0, fails = 0;

    mc6502_interrupt_sequencer dut (
        .clk(clk), .rst_x(rst_x), .cen(cen), .i_nmi_n(i_nmi_n), .i_irq_n(i_irq_n),
        .i_brk(i_brk), .i_fetch(i_fetch), .i_pc(i_pc), .i_sp(i_sp), .i_psr(i_psr),
        .i_rdata(i_rdata), .o_busy(o_busy), .o_addr(o_addr), .o_wdata(o_wdata), .o_we(o_we),
        .o_sp_dec(o_sp_dec), .o_set_i(o_set_i), .o_i(o_i), .o_set_b(o_set_b), .o_b(o_b),
        .o_set_d(o_set_d), .o_d(o_d), .o_pc_load(o_pc_load), .o_pc(o_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        case (a)
            16'hFFFA: mem = 8'h78;
            16'hFFFB: mem = 8'h56;
            16'hFFFC: mem = 8'h34;
            16'hFFFD: mem = 8'h12;
            16'hFFFE: mem = 8'hBC;
            16'hFFFF: mem = 8'h9A;
            default:  mem = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign i_rdata = mem(o_addr);

    // Model: m_step counts cycles into a sequence (0 = no sequence, 1..7 = cycle number)
    int          m_step = 0, m_kind = 0;
    logic        m_res = 1'b1, m_nmi = 1'b0, m_prev = 1'b1, m_hij = 1'b0;
    logic [15:0] m_pc = 16'h0000, m_opc = 16'h0000;
    logic [7:0]  m_sp = 8'h00;

    function automatic logic [15:0] m_vec();
        return (m_kind == 0) ? 16'hFFFC : (m_kind == 1 || m_hij) ? 16'hFFFA : 16'hFFFE;
    endfunction

    always @(posedge clk or negedge rst_x) begin
        logic nmi_fall, irq_req;
        if (!rst_x) begin
            m_step = 0; m_kind = 0; m_res = 1'b1; m_nmi = 1'b0; m_prev = 1'b1; m_hij = 1'b0;
            m_pc = 16'h0000; m_sp = 8'h00; m_opc = 16'h0000;
        end else if (cen) begin
            nmi_fall = m_prev && !i_nmi_n;
            m_prev   = i_nmi_n;
            irq_req  = !i_irq_n && !i_psr[2];
            if (m_step == 0) begin
                if (m_res || (i_fetch && (m_nmi || irq_req || i_brk))) begin
                    m_kind = m_res ? 0 : m_nmi ? 1 : irq_req ? 2 : 3;
                    m_pc = i_pc; m_sp = i_sp; m_hij = 1'b0; m_step = 1;
                end
            end else begin
                if (m_step == 4) m_hij = (m_kind >= 2) && (m_nmi || nmi_fall);
                if (m_step == 5) begin
                    m_opc[7:0] = mem(m_vec());
                    m_res = 1'b0;
                    if (m_kind == 1 || m_hij) m_nmi = 1'b0;
                end
                if (m_step == 6) m_opc[15:8] = mem(m_vec() + 16'd1);
                m_step = (m_step == 7) ? 0 : m_step + 1;
            end
            if (nmi_fall) m_nmi = 1'b1;
        end
    end

    function automatic logic [49:0] expected();
        logic        push, v5;
        logic [15:0] a;
        logic [7:0]  wd;
        push = (m_step >= 2) && (m_step <= 4);
        v5   = (m_step == 5);
        a  = (m_step == 1) ? m_pc : push ? {8'h01, m_sp - 8'(m_step - 2)} :
             (m_step == 5) ? m_vec() : (m_step == 6) ? m_vec() + 16'd1 : 16'h0000;
        wd = (m_step == 2) ? m_pc[15:8] : (m_step == 3) ? m_pc[7:0] :
             (m_step == 4) ? {i_psr[7:6], 1'b1, m_kind == 3, i_psr[3:0]} : 8'h00;
`ifdef MC6502_CMOS_CLEAR_D_EN
        return {m_step != 0, a, wd, push && m_kind != 0, push, v5, v5, v5, v5 && m_kind == 3,
                v5, 1'b0, m_step == 7, m_opc};
`else
        return {m_step != 0, a, wd, push && m_kind != 0, push, v5, v5, v5, v5 && m_kind == 3,
                1'b0, 1'b0, m_step == 7, m_opc};
`endif
    endfunction

    always @(negedge clk) begin
        logic [49:0] got, exp;
        got = {o_busy, o_addr, o_wdata, o_we, o_sp_dec, o_set_i, o_i, o_set_b, o_b,
               o_set_d, o_d, o_pc_load, o_pc};
        exp = expected();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    int          c_cyc, c_wr, c_dec;
    logic [15:0] c_waddr [8];
    logic [15:0] c_daddr [8];
    logic [7:0]  c_wdat [8];
    logic [15:0] c_vaddr, c_pc;
    logic        c_i, c_b, c_done;

    // Observe one sequence; nmi_at drops i_nmi_n during that sequence cycle (1-based)
    task automatic capture(input int nmi_at);
        c_cyc = 0; c_wr = 0; c_dec = 0; c_done = 1'b0;
        c_vaddr = 16'h0000; c_pc = 16'h0000; c_i = 1'b0; c_b = 1'b0;
        for (int k = 0; k < 20 && !c_done; k++) begin
            @(negedge clk);
            if (o_busy) begin
                c_cyc++;
                if (c_cyc == nmi_at) i_nmi_n = 1'b0;
            end
            if (o_we && c_wr < 8) begin c_waddr[c_wr] = o_addr; c_wdat[c_wr] = o_wdata; c_wr++; end
            if (o_sp_dec && c_dec < 8) begin c_daddr[c_dec] = o_addr; c_dec++; end
            if (o_set_i) begin c_vaddr = o_addr; c_i = o_i; c_b = o_b; end
            if (o_pc_load) begin c_pc = o_pc; c_done = 1'b1; end
        end
        check("seq_done", 32'(c_done), 32'd1);
    endtask

    task automatic fetch(input logic brk);
        @(posedge clk); #1 i_fetch = 1'b1; i_brk = brk;
        @(posedge clk); #1 i_fetch = 1'b0; i_brk = 1'b0;
    endtask

    task automatic busy_cycles(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_busy) cnt++;
        end
    endtask

    initial begin
        int nb;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_addr", 32'(o_addr), 32'h0000);
        check("rst_pc", 32'(o_pc), 32'h0000);
        rst_x = 1'b1;
        capture(0);
        check("res_cycles", c_cyc, 7);
        check("res_writes", c_wr, 0);
        check("res_spdec", c_dec, 3);
        check("res_addrs", {c_daddr[0], c_daddr[1]}, 32'h010001FF);
        check("res_addr2", 32'(c_daddr[2]), 32'h01FE);
        check("res_vec", 32'(c_vaddr), 32'hFFFC);
        check("res_pc", 32'(c_pc), 32'h1234);
        check("res_i", 32'(c_i), 32'd1);

        i_pc = 16'hC000; i_sp = 8'hFF; i_psr = 8'h00; i_irq_n = 1'b0;
        fetch(1'b0);
        capture(0);
        i_irq_n = 1'b1;
        check("irq_cycles", c_cyc, 7);
        check("irq_nwr", c_wr, 3);
        check("irq_w0", {c_waddr[0], c_wdat[0]}, 32'h0001FFC0);
        check("irq_w1", {c_waddr[1], c_wdat[1]}, 32'h0001FE00);
        check("irq_w2", {c_waddr[2], c_wdat[2]}, 32'h0001FD20);
        check("irq_vec", 32'(c_vaddr), 32'hFFFE);
        check("irq_ib", {c_i, c_b}, 32'd2);
        check("irq_pc", 32'(c_pc), 32'h9ABC);

        i_psr = 8'h04; i_irq_n = 1'b0;
        fetch(1'b0);
        busy_cycles(10, nb);
        i_irq_n = 1'b1;
        check("irq_masked", nb, 0);

        i_psr = 8'hC3; i_pc = 16'h2345;
        fetch(1'b1);
        capture(0);
        check("brk_p", 32'(c_wdat[2]), 32'hF3);
        check("brk_vec", 32'(c_vaddr), 32'hFFFE);
        check("brk_b", 32'(c_b), 32'd1);

        i_psr = 8'h00; i_irq_n = 1'b0;
        fetch(1'b0);
        capture(2);
        i_irq_n = 1'b1; i_nmi_n = 1'b1;
        check("hij_vec", 32'(c_vaddr), 32'hFFFA);
        check("hij_p", 32'(c_wdat[2]), 32'h20);
        check("hij_pc", 32'(c_pc), 32'h5678);
        fetch(1'b0);
        busy_cycles(10, nb);
        check("hij_nmi_cleared", nb, 0);

        fetch(1'b1);
        capture(6);
        check("late_brk_vec", 32'(c_vaddr), 32'hFFFE);
        check("late_brk_pc", 32'(c_pc), 32'h9ABC);
        busy_cycles(5, nb);
        check("late_nmi_waits", nb, 0);
        i_nmi_n = 1'b1;
        fetch(1'b0);
        capture(0);
        check("late_nmi_vec", 32'(c_vaddr), 32'hFFFA);
        check("late_nmi_pc", 32'(c_pc), 32'h5678);
        check("late_nmi_b", 32'(c_b), 32'd0);

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            cen     = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) i_nmi_n = ~i_nmi_n;
            i_irq_n = ($urandom_range(3) != 0);
            i_fetch = ($urandom_range(3) == 0);
            i_brk   = 1'($urandom_range(1));
            i_pc    = 16'($urandom);
            i_sp    = 8'($urandom);
            i_psr   = 8'($urandom);
            rst_x   = ($urandom_range(499) != 0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
